// File: rtl/regfile_param_if.sv
// Bundled read/write/clear signals of the parametrised register file.
// The master side drives addresses, write requests and clr; the slave side is the register file.
interface regfile_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              write0;
  logic [ADDR_W-1:0] write_reg0;
  logic [DATA_W-1:0] write_data0;
  logic              write1;
  logic [ADDR_W-1:0] write_reg1;
  logic [DATA_W-1:0] write_data1;
  logic              clr;
  logic              busy;
  logic              wr_drop;

  modport master (
    output read_reg1, read_reg2, write0, write_reg0, write_data0,
           write1, write_reg1, write_data1, clr,
    input  read_data1, read_data2, busy, wr_drop
  );

  modport slave (
    input  read_reg1, read_reg2, write0, write_reg0, write_data0,
           write1, write_reg1, write_data1, clr,
    output read_data1, read_data2, busy, wr_drop
  );
endinterface

// File: rtl/regfile_param.sv
// Register file with 2 async read ports, 2 prioritised write ports, optional bypass and zero r0,
// and a clear engine that zeroes one entry per cycle while writes are rejected.
module regfile_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 2,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input logic            clk,
  input logic            reset,
  regfile_param_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] mem_d [Depth];
  logic              clearing;
  logic              we0, we1;
  logic [DATA_W-1:0] rd1, rd2;

  assign clearing = (state_q == StClear);

  // Accepted writes: only in idle, and never into a hardwired-zero r0.
  assign we0 = bus.write0 && !clearing && !(ZERO_R0 && (bus.write_reg0 == '0));
  assign we1 = bus.write1 && !clearing && !(ZERO_R0 && (bus.write_reg1 == '0));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    drop_d  = 1'b0;
    mem_d   = mem_q;
    unique case (state_q)
      StIdle: begin
        // Port 1 first so port 0 wins on an address collision.
        if (we1) mem_d[bus.write_reg1] = bus.write_data1;
        if (we0) mem_d[bus.write_reg0] = bus.write_data0;
        if (bus.clr) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        mem_d[ptr_q] = '0;
        ptr_d        = ptr_q + ADDR_W'(1);
        drop_d       = bus.write0 | bus.write1;
        if (&ptr_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    rd1 = mem_q[bus.read_reg1];
    if (BYPASS) begin
      if (we1 && (bus.write_reg1 == bus.read_reg1)) rd1 = bus.write_data1;
      if (we0 && (bus.write_reg0 == bus.read_reg1)) rd1 = bus.write_data0;
    end
    if (ZERO_R0 && (bus.read_reg1 == '0)) rd1 = '0;
  end

  always_comb begin
    rd2 = mem_q[bus.read_reg2];
    if (BYPASS) begin
      if (we1 && (bus.write_reg1 == bus.read_reg2)) rd2 = bus.write_data1;
      if (we0 && (bus.write_reg0 == bus.read_reg2)) rd2 = bus.write_data0;
    end
    if (ZERO_R0 && (bus.read_reg2 == '0)) rd2 = '0;
  end

  assign bus.read_data1 = rd1;
  assign bus.read_data2 = rd2;
  assign bus.busy       = clearing;
  assign bus.wr_drop    = drop_q;
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the microprocessor's 4x8 register file: 2^ADDR_W entries of DATA_W bits.
- Two asynchronous read ports and two synchronous write ports, with fixed write-port priority.
- Optional read-after-write bypass and optional hardwired-zero register 0.
- A sequenced clear engine scrubs the array one entry per cycle without asserting reset.
- Sits between decode and ALU in the datapath.

Parameters:
DATA_W, 8, width of each register
ADDR_W, 2, address width; DEPTH = 2^ADDR_W
BYPASS, 1, 1 = a read of the address being written this cycle returns the write data
ZERO_R0, 0, 1 = entry 0 always reads 0 and ignores writes

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
read_reg1  in  ADDR_W  read port 1 address
read_reg2  in  ADDR_W  read port 2 address
read_data1  out  DATA_W  read port 1 data, combinational
read_data2  out  DATA_W  read port 2 data, combinational
write0  in  1  write enable, port 0 (higher priority)
write_reg0  in  ADDR_W  write address, port 0
write_data0  in  DATA_W  write data, port 0
write1  in  1  write enable, port 1
write_reg1  in  ADDR_W  write address, port 1
write_data1  in  DATA_W  write data, port 1
clr  in  1  start sequenced clear (level sampled at posedge)
busy  out  1  clear engine active
wr_drop  out  1  one-cycle pulse: at least one write enable was discarded on the previous edge

Behaviour:
- Reset:
  - Sampled at posedge with reset==0.
  - All entries become 0; FSM goes to IDLE; clear pointer = 0; busy=0; wr_drop=0.
  - Reset overrides clr and all writes in the same cycle.
  - Reset mid-clear aborts the clear; the array is zeroed by reset itself.
- Writes (FSM in IDLE only):
  - Commit at posedge when write0/write1 are high.
  - write0 and write1 to the same address: port 0 data is stored; port 1 is silently lost. This is not a drop, so wr_drop stays 0.
  - Different addresses: both commit in the same cycle.
  - ZERO_R0=1: writes to address 0 are ignored (not flagged as a drop).
- Reads:
  - Combinational: read_dataN = array[read_regN].
  - BYPASS=1: if an enabled, accepted write targets read_regN this cycle, read_dataN = that write's data, applying port 0 priority.
  - BYPASS=0: reads show the old value until after the edge.
  - ZERO_R0=1: address 0 reads 0 regardless of bypass.
  - Reads are valid during clear and show current array contents. Bypass is inactive while busy, since writes are not accepted.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR at posedge with clr=1. The pointer is set to 0 and busy=1 from the next cycle.
  - Writes and clr sampled on that same start edge still commit normally.
  - In CLEAR, each posedge writes 0 to array[ptr] and then ptr++.
  - On the edge that clears entry DEPTH-1, the FSM goes to IDLE and busy drops the next cycle.
  - Clear takes exactly DEPTH cycles with busy=1.
  - The pointer is ADDR_W bits wide; its wrap to 0 coincides with the return to IDLE.
  - clr asserted while in CLEAR is ignored (no restart).
- Writes during CLEAR:
  - Any write0/write1 high at a posedge while busy=1 is discarded.
  - wr_drop=1 for the following cycle. It is registered, one cycle wide, and re-asserts every cycle a drop occurs.
- Timing: no other latency; all state changes on rising edge.

Test Plan:
1. Reset then basic write/read (defaults):
   - reset=0 for one edge -> all reads 0.
   - write0 reg 2 = 0x55 -> after edge, read_reg1=2 gives 0x55.
   - Then write reg 3 = 0xCC with read_reg1=3 in the same cycle -> read_data1=0xCC combinationally before the edge (bypass).
2. Dual-write conflict:
   - Same cycle, write0 reg1=0xAA and write1 reg1=0x11 -> reg1=0xAA, wr_drop=0.
   - Different addresses (reg0=0x01, reg3=0x02) -> both stored.
3. Clear sequence:
   - Fill regs with 0x10..0x13, pulse clr one cycle -> busy=1 for exactly 4 cycles.
   - read_reg2 tracks entries going to 0 in order 0..3.
   - After busy falls, all reads are 0.
4. Write during clear:
   - write0 reg3=0xFF on the second busy cycle -> wr_drop=1 the next cycle only.
   - reg3 is 0 after clear.
   - clr re-pulsed while busy -> busy length is still 4.
5. Reset mid-clear:
   - reset=0 on the second busy cycle -> busy=0 the next cycle; all entries 0; a new clr works normally.
6. Parameter sweep:
   - DATA_W=16, ADDR_W=3, BYPASS=0, ZERO_R0=1.
   - Write r0=0xBEEF -> r0 reads 0.
   - Write r7=0x1234 with read_reg1=7 -> old value before the edge, 0x1234 after.
   - Clear takes 8 cycles.
